pmem_arbiter: RTL

PMEM_ARBITER -- requirements
Module: pmem_arbiter

---
 rtl/pmem_arbiter_if.sv | 40 ++++
 rtl/pmem_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: fetch, data and memory signals between requesters, arbiter and program memory
interface pmem_arbiter_if #(
    parameter int PC_WIDTH   = 12,
    parameter int PMEM_WIDTH = 16
);
    logic                  in_fetch_req;
    logic [PC_WIDTH-1:0]   in_fetch_addr;
    logic                  out_fetch_gnt;
    logic                  out_fetch_valid;
    logic [PMEM_WIDTH-1:0] out_fetch_data;
    logic                  out_stall;
    logic                  in_dmem_req;
    logic                  in_dmem_we;
    logic [PC_WIDTH-1:0]   in_dmem_addr;
    logic [PMEM_WIDTH-1:0] in_dmem_wdata;
    logic                  out_dmem_gnt;
    logic                  out_dmem_valid;
    logic [PMEM_WIDTH-1:0] out_dmem_rdata;
    logic                  out_pmem_en;
    logic                  out_pmem_we;
    logic [PC_WIDTH-1:0]   out_pmem_addr;
    logic [PMEM_WIDTH-1:0] out_pmem_wdata;
    logic [PMEM_WIDTH-1:0] in_pmem_rdata;

    modport slave (
        input  in_fetch_req, in_fetch_addr, in_dmem_req, in_dmem_we, in_dmem_addr,
               in_dmem_wdata, in_pmem_rdata,
        output out_fetch_gnt, out_fetch_valid, out_fetch_data, out_stall, out_dmem_gnt,
               out_dmem_valid, out_dmem_rdata, out_pmem_en, out_pmem_we, out_pmem_addr,
               out_pmem_wdata
    );

    modport master (
        output in_fetch_req, in_fetch_addr, in_dmem_req, in_dmem_we, in_dmem_addr,
               in_dmem_wdata, in_pmem_rdata,
        input  out_fetch_gnt, out_fetch_valid, out_fetch_data, out_stall, out_dmem_gnt,
               out_dmem_valid, out_dmem_rdata, out_pmem_en, out_pmem_we, out_pmem_addr,
               out_pmem_wdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: single-port program memory shared by fetch and data ports; PMEM_ARB_STARVE_EN enables fetch anti-starvation
module pmem_arbiter #(
    parameter int PC_WIDTH     = 12,
    parameter int PMEM_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    pmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

    owner_t owner, owner_next;
    logic   fetch_pri;
    logic   fetch_gnt;
    logic   dmem_gnt;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT out of range 1..15");
    end

`ifdef PMEM_ARB_STARVE_EN
    logic [3:0] starve_cnt, starve_cnt_next;
    logic       force_fetch, force_fetch_next;

    // count consecutive fetch denials; force fetch once the limit is reached
    always_comb begin
        starve_cnt_next  = (!bus.in_fetch_req || fetch_gnt) ? 4'd0 :
                           (starve_cnt == 4'd15) ? 4'd15 : starve_cnt + 4'd1;
        force_fetch_next = fetch_gnt ? 1'b0 :
                           (force_fetch || starve_cnt_next >= 4'(STARVE_LIMIT));
    end

    // starvation state register
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt  <= 4'd0;
            force_fetch <= 1'b0;
        end else begin
            starve_cnt  <= starve_cnt_next;
            force_fetch <= force_fetch_next;
        end
    end

    assign fetch_pri = force_fetch;
`else
    assign fetch_pri = 1'b0;
`endif

    // grant selection, memory mux and owner next-state; reset blocks all grants
    always_comb begin
        fetch_gnt          = !reset && bus.in_fetch_req && (!bus.in_dmem_req || fetch_pri);
        dmem_gnt           = !reset && bus.in_dmem_req && !fetch_gnt;
        bus.out_fetch_gnt  = fetch_gnt;
        bus.out_dmem_gnt   = dmem_gnt;
        bus.out_stall      = bus.in_fetch_req && !fetch_gnt;
        bus.out_pmem_en    = fetch_gnt || dmem_gnt;
        bus.out_pmem_we    = dmem_gnt && bus.in_dmem_we;
        bus.out_pmem_addr  = fetch_gnt ? bus.in_fetch_addr : dmem_gnt ? bus.in_dmem_addr : '0;
        bus.out_pmem_wdata = (fetch_gnt || dmem_gnt) ? bus.in_dmem_wdata : '0;
        owner_next         = fetch_gnt ? OWN_FETCH :
                             (dmem_gnt && !bus.in_dmem_we) ? OWN_DATA : OWN_NONE;
    end

    // remember who owns the read data returning next cycle
    always_ff @(posedge clock) begin
        if (reset) owner <= OWN_NONE;
        else       owner <= owner_next;
    end

    // steer returning read data to its owner; silent during reset
    always_comb begin
        bus.out_fetch_valid = !reset && owner == OWN_FETCH;
        bus.out_dmem_valid  = !reset && owner == OWN_DATA;
        bus.out_fetch_data  = bus.out_fetch_valid ? bus.in_pmem_rdata : '0;
        bus.out_dmem_rdata  = bus.out_dmem_valid ? bus.in_pmem_rdata : '0;
    end
endmodule
